// File: rtl/atetris_input_cond_pkg.sv
// Shared constants for the Atari Tetris input conditioner: PS/2 scan codes,
// INP bus bit positions, joystick bit layout and key-state register indices.
package atetris_inp_pkg;

  // Arrow keys are matched on the 8-bit code only; the extended flag is ignored
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Remaining keys are matched on {extended, code}
  localparam logic [8:0] SC_P1_ROT       = 9'h029;
  localparam logic [8:0] SC_P1_START     = 9'h016;
  localparam logic [8:0] SC_P1_START_ALT = 9'h005;
  localparam logic [8:0] SC_COIN1        = 9'h02E;
  localparam logic [8:0] SC_COIN2        = 9'h006;
  localparam logic [8:0] SC_COIN2_ALT    = 9'h036;
  localparam logic [8:0] SC_P2_UP        = 9'h02D;
  localparam logic [8:0] SC_P2_DOWN      = 9'h02B;
  localparam logic [8:0] SC_P2_LEFT      = 9'h023;
  localparam logic [8:0] SC_P2_RIGHT     = 9'h034;
  localparam logic [8:0] SC_P2_ROT       = 9'h01C;

  localparam int INP_P1RO = 0;
  localparam int INP_P1D  = 1;
  localparam int INP_P1R  = 2;
  localparam int INP_P1L  = 3;
  localparam int INP_P2RO = 4;
  localparam int INP_P2D  = 5;
  localparam int INP_P2R  = 6;
  localparam int INP_P2L  = 7;
  localparam int INP_C1   = 8;
  localparam int INP_C2   = 9;
  localparam int INP_TEST = 10;

  typedef enum logic [3:0] {
    JOY_R    = 4'd0,
    JOY_L    = 4'd1,
    JOY_D    = 4'd2,
    JOY_U    = 4'd3,
    JOY_ROT  = 4'd4,
    JOY_COIN = 4'd5
  } joy_bit_e;

  // Direction vectors share the joystick order {U,D,L,R}
  localparam int DIR_R = 0;
  localparam int DIR_L = 1;
  localparam int DIR_D = 2;
  localparam int DIR_U = 3;

  localparam int KEY_P1_U         = 0;
  localparam int KEY_P1_D         = 1;
  localparam int KEY_P1_L         = 2;
  localparam int KEY_P1_R         = 3;
  localparam int KEY_P1_ROT       = 4;
  localparam int KEY_P1_START     = 5;
  localparam int KEY_P1_START_ALT = 6;
  localparam int KEY_COIN1        = 7;
  localparam int KEY_COIN2        = 8;
  localparam int KEY_COIN2_ALT    = 9;
  localparam int KEY_P2_U         = 10;
  localparam int KEY_P2_D         = 11;
  localparam int KEY_P2_L         = 12;
  localparam int KEY_P2_R         = 13;
  localparam int KEY_P2_ROT       = 14;
  localparam int N_KEYS           = 15;

  // One-hot of the highest-priority newly pressed direction, U > D > L > R
  function automatic logic [3:0] newest_dir(input logic [3:0] fresh);
    logic [3:0] oh;
    oh = 4'b0000;
    if (fresh[DIR_U])      oh[DIR_U] = 1'b1;
    else if (fresh[DIR_D]) oh[DIR_D] = 1'b1;
    else if (fresh[DIR_L]) oh[DIR_L] = 1'b1;
    else if (fresh[DIR_R]) oh[DIR_R] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/atetris_input_cond_arb.sv
// Last-pressed-wins arbitration over one player's {U,D,L,R}: only the most
// recently pressed direction is passed, and only while it stays held.
module one_dir_arb
  import atetris_inp_pkg::*;
(
  input  logic       clk_sys,
  input  logic       RESET,
  input  logic [3:0] dir_in,
  output logic [3:0] dir_out
);

  logic [3:0] dir_q;
  logic [3:0] prev_q;
  logic [3:0] mask_q;
  logic [3:0] fresh;
  logic [3:0] mask_eff;

  // The mask is applied in the same cycle the new press is seen, keeping
  // the joystick-to-INP path at two registers.
  always_comb begin
    fresh    = dir_q & ~prev_q;
    mask_eff = (fresh != 4'b0000) ? newest_dir(fresh) : mask_q;
  end

  assign dir_out = dir_q & mask_eff;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      dir_q  <= 4'b0000;
      prev_q <= 4'b0000;
      mask_q <= 4'b0000;
    end else begin
      dir_q  <= dir_in;
      prev_q <= dir_q;
      mask_q <= mask_eff;
    end
  end

endmodule

// File: rtl/atetris_input_cond.sv
// Merges PS/2 keyboard and joystick inputs into the game core's active-low
// INP bus, with per-player direction arbitration and coin pulse stretching.
module atetris_input_cond
  import atetris_inp_pkg::*;
#(
  parameter int COIN_PULSE = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystk1,
  input  logic [15:0] joystk2,
  input  logic        self_test,
  output logic [10:0] INP
);

  logic              tog_q;
  logic [N_KEYS-1:0] key_q;
  logic [N_KEYS-1:0] key_d;
  logic [3:0]        p1_dir_m;
  logic [3:0]        p2_dir_m;
  logic [3:0]        p1_dir;
  logic [3:0]        p2_dir;
  logic              p1_rot_m;
  logic              p2_rot_m;
  logic              coin1_m;
  logic              coin2_m;
  logic              p1_rot_q;
  logic              p2_rot_q;
  logic              test_q;
  logic              coin1_q;
  logic              coin1_p;
  logic              coin2_q;
  logic              coin2_p;
  logic [CNT_W-1:0]  cnt1_q;
  logic [CNT_W-1:0]  cnt2_q;
  logic [10:0]       inp_d;
  logic              unused_joy;

  assign unused_joy = ^{joystk1[15:6], joystk2[15:6]};

  always_comb begin
    key_d = key_q;
    if (ps2_key[10] != tog_q) begin
      case (ps2_key[7:0])
        SC_UP:    key_d[KEY_P1_U] = ps2_key[9];
        SC_DOWN:  key_d[KEY_P1_D] = ps2_key[9];
        SC_LEFT:  key_d[KEY_P1_L] = ps2_key[9];
        SC_RIGHT: key_d[KEY_P1_R] = ps2_key[9];
        default: begin
          case (ps2_key[8:0])
            SC_P1_ROT:       key_d[KEY_P1_ROT]       = ps2_key[9];
            SC_P1_START:     key_d[KEY_P1_START]     = ps2_key[9];
            SC_P1_START_ALT: key_d[KEY_P1_START_ALT] = ps2_key[9];
            SC_COIN1:        key_d[KEY_COIN1]        = ps2_key[9];
            SC_COIN2:        key_d[KEY_COIN2]        = ps2_key[9];
            SC_COIN2_ALT:    key_d[KEY_COIN2_ALT]    = ps2_key[9];
            SC_P2_UP:        key_d[KEY_P2_U]         = ps2_key[9];
            SC_P2_DOWN:      key_d[KEY_P2_D]         = ps2_key[9];
            SC_P2_LEFT:      key_d[KEY_P2_L]         = ps2_key[9];
            SC_P2_RIGHT:     key_d[KEY_P2_R]         = ps2_key[9];
            SC_P2_ROT:       key_d[KEY_P2_ROT]       = ps2_key[9];
            default: ;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    p1_dir_m = {joystk1[JOY_U], joystk1[JOY_D], joystk1[JOY_L], joystk1[JOY_R]} |
               {key_q[KEY_P1_U], key_q[KEY_P1_D], key_q[KEY_P1_L], key_q[KEY_P1_R]};
    p2_dir_m = {joystk2[JOY_U], joystk2[JOY_D], joystk2[JOY_L], joystk2[JOY_R]} |
               {key_q[KEY_P2_U], key_q[KEY_P2_D], key_q[KEY_P2_L], key_q[KEY_P2_R]};
    p1_rot_m = joystk1[JOY_ROT] | key_q[KEY_P1_ROT];
    p2_rot_m = joystk2[JOY_ROT] | key_q[KEY_P2_ROT];
    coin1_m  = joystk1[JOY_COIN] | key_q[KEY_P1_START] | key_q[KEY_P1_START_ALT] |
               key_q[KEY_COIN1];
    coin2_m  = joystk2[JOY_COIN] | key_q[KEY_COIN2] | key_q[KEY_COIN2_ALT];
  end

  one_dir_arb u_arb_p1 (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .dir_in  (p1_dir_m),
    .dir_out (p1_dir)
  );

  one_dir_arb u_arb_p2 (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .dir_in  (p2_dir_m),
    .dir_out (p2_dir)
  );

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      tog_q    <= ps2_key[10];
      key_q    <= '0;
      p1_rot_q <= 1'b0;
      p2_rot_q <= 1'b0;
      test_q   <= 1'b0;
      coin1_q  <= 1'b0;
      coin1_p  <= 1'b0;
      coin2_q  <= 1'b0;
      coin2_p  <= 1'b0;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
    end else begin
      tog_q    <= ps2_key[10];
      key_q    <= key_d;
      p1_rot_q <= p1_rot_m;
      p2_rot_q <= p2_rot_m;
      test_q   <= self_test;
      coin1_q  <= coin1_m;
      coin1_p  <= coin1_q;
      coin2_q  <= coin2_m;
      coin2_p  <= coin2_q;
      // A pulse only starts from idle, so holding or re-tapping never stretches it
      if (coin1_q && !coin1_p && cnt1_q == '0) cnt1_q <= CNT_W'(COIN_PULSE);
      else if (cnt1_q != '0)                   cnt1_q <= cnt1_q - CNT_W'(1);
      if (coin2_q && !coin2_p && cnt2_q == '0) cnt2_q <= CNT_W'(COIN_PULSE);
      else if (cnt2_q != '0)                   cnt2_q <= cnt2_q - CNT_W'(1);
    end
  end

  always_comb begin
    inp_d           = '0;
    inp_d[INP_TEST] = test_q;
    inp_d[INP_C2]   = (cnt2_q != '0);
    inp_d[INP_C1]   = (cnt1_q != '0);
    inp_d[INP_P2L]  = p2_dir[DIR_L];
    inp_d[INP_P2R]  = p2_dir[DIR_R];
    inp_d[INP_P2D]  = p2_dir[DIR_D];
    inp_d[INP_P2RO] = p2_rot_q;
    inp_d[INP_P1L]  = p1_dir[DIR_L];
    inp_d[INP_P1R]  = p1_dir[DIR_R];
    inp_d[INP_P1D]  = p1_dir[DIR_D];
    inp_d[INP_P1RO] = p1_rot_q;
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) INP <= 11'h7FF;
    else       INP <= ~inp_d;
  end

endmodule

// File: tb/tb_atetris_input_cond.sv
// Scoreboard bench for atetris_input_cond: a behavioural model predicts INP for
// every clock edge; an independent monitor pops and compares after each edge.
module tb_atetris_input_cond;

  localparam int COIN_P = 50;

  logic        clk_sys = 1'b0;
  logic        RESET = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [15:0] joystk1 = '0;
  logic [15:0] joystk2 = '0;
  logic        self_test = 1'b0;
  logic [10:0] INP;

  atetris_input_cond #(.COIN_PULSE(COIN_P), .CNT_W(8)) dut (
    .clk_sys   (clk_sys),
    .RESET     (RESET),
    .ps2_key   (ps2_key),
    .joystk1   (joystk1),
    .joystk2   (joystk2),
    .self_test (self_test),
    .INP       (INP)
  );

  always #5 clk_sys = ~clk_sys;

  logic [10:0] sb_q[$];
  int vectors = 0;
  int miscompares = 0;
  int edge_no = 0;

  // Reference model state: pressed keys by {ext,code}, newest-direction owner
  // per player, and coin pulses as [start,end] edge intervals on INP.
  bit          key_m[512];
  logic        tog_m;
  logic [3:0]  prev1, prev2;
  int          own1, own2;
  bit          prevc1, prevc2;
  int          c1_s, c1_e, c2_s, c2_e;
  logic [10:0] pending = 11'h7FF;
  int          t = 0;

  function automatic bit covered(int e, int s, int en);
    return (e >= s) && (e <= en);
  endfunction

  function automatic int pick_owner(logic [3:0] m, logic [3:0] p, int cur);
    for (int d = 3; d >= 0; d--)
      if (m[d] && !p[d]) return d;
    return cur;
  endfunction

  function automatic logic [3:0] owned(int own, logic [3:0] m);
    logic [3:0] o;
    o = 4'b0000;
    if (own >= 0 && own != 3 && m[own]) o[own] = 1'b1;
    return o;
  endfunction

  task automatic model_step();
    logic [10:0] want;
    logic [3:0]  m1, m2, o1, o2;
    logic [8:0]  idx;
    bit          r1, r2, c1, c2;
    sb_q.push_back(RESET ? 11'h7FF : pending);
    if (RESET) begin
      for (int i = 0; i < 512; i++) key_m[i] = 1'b0;
      tog_m = ps2_key[10];
      prev1 = 4'b0; prev2 = 4'b0; own1 = -1; own2 = -1;
      prevc1 = 1'b0; prevc2 = 1'b0;
      c1_s = 0; c1_e = -1; c2_s = 0; c2_e = -1;
      pending = 11'h7FF;
    end else begin
      m1 = joystk1[3:0] | {key_m[9'h075], key_m[9'h072], key_m[9'h06B], key_m[9'h074]};
      m2 = joystk2[3:0] | {key_m[9'h02D], key_m[9'h02B], key_m[9'h023], key_m[9'h034]};
      r1 = joystk1[4] | key_m[9'h029];
      r2 = joystk2[4] | key_m[9'h01C];
      c1 = joystk1[5] | key_m[9'h016] | key_m[9'h005] | key_m[9'h02E];
      c2 = joystk2[5] | key_m[9'h006] | key_m[9'h036];
      own1 = pick_owner(m1, prev1, own1);
      own2 = pick_owner(m2, prev2, own2);
      o1 = owned(own1, m1);
      o2 = owned(own2, m2);
      if (c1 && !prevc1 && !covered(t + 1, c1_s, c1_e)) begin
        c1_s = t + 2; c1_e = t + 1 + COIN_P;
      end
      if (c2 && !prevc2 && !covered(t + 1, c2_s, c2_e)) begin
        c2_s = t + 2; c2_e = t + 1 + COIN_P;
      end
      want     = '0;
      want[10] = self_test;
      want[9]  = covered(t + 1, c2_s, c2_e);
      want[8]  = covered(t + 1, c1_s, c1_e);
      want[7]  = o2[1];
      want[6]  = o2[0];
      want[5]  = o2[2];
      want[4]  = r2;
      want[3]  = o1[1];
      want[2]  = o1[0];
      want[1]  = o1[2];
      want[0]  = r1;
      pending  = ~want;
      if (ps2_key[10] !== tog_m) begin
        idx = ps2_key[8:0];
        if (ps2_key[7:0] == 8'h75 || ps2_key[7:0] == 8'h72 ||
            ps2_key[7:0] == 8'h6B || ps2_key[7:0] == 8'h74) idx[8] = 1'b0;
        key_m[idx] = ps2_key[9];
        tog_m = ps2_key[10];
      end
      prev1 = m1; prev2 = m2; prevc1 = c1; prevc2 = c2;
    end
    t++;
  endtask

  // Inputs are set at a negedge, the model predicts the next edge, then time moves on
  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk_sys);
    end
  endtask

  task automatic ps2_ev(bit pressed, bit ext, logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  always @(posedge clk_sys) begin
    #1;
    edge_no++;
    if (sb_q.size() > 0) begin
      logic [10:0] exp_v;
      exp_v = sb_q.pop_front();
      vectors++;
      if (INP !== exp_v) begin
        miscompares++;
        $display("FAIL inp edge %0d: got %h expected %h", edge_no, INP, exp_v);
      end
    end
  end

  logic [7:0] codes[17] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h16, 8'h05, 8'h2E,
                            8'h06, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1A, 8'h5A};

  initial begin
    @(negedge clk_sys);
    // reset, with a toggle landing on the final reset cycle
    RESET = 1'b1;
    tick(3);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h29};
    tick();
    RESET = 1'b0;
    tick(10);

    // keyboard up then left: U suppresses nothing once left is newer
    ps2_ev(1'b1, 1'b1, 8'h75);
    tick(3);
    ps2_ev(1'b1, 1'b1, 8'h6B);
    tick(4);
    ps2_ev(1'b0, 1'b1, 8'h6B);
    tick(4);
    ps2_ev(1'b0, 1'b1, 8'h75);
    tick(3);

    // simultaneous L+D, then R added
    joystk1 = 16'h0006; tick(3);
    joystk1 = 16'h0007; tick(3);
    joystk1 = 16'h0000; tick(3);

    // coin1 key held 3 cycles, then a re-tap around the end of the pulse
    ps2_ev(1'b1, 1'b0, 8'h2E);
    tick(2);
    ps2_ev(1'b0, 1'b0, 8'h2E);
    tick(COIN_P - 2);
    for (int k = 0; k < 6; k++) begin
      ps2_ev(1'b1, 1'b0, 8'h2E);
      ps2_ev(1'b0, 1'b0, 8'h2E);
    end
    tick(COIN_P + 5);

    // coin2 joystick double pulse inside one stretch
    joystk2 = 16'h0020; tick();
    joystk2 = 16'h0000; tick(4);
    joystk2 = 16'h0020; tick();
    joystk2 = 16'h0000; tick(COIN_P + 5);

    // reset mid-pulse with P2 rotate held
    joystk2 = 16'h0030; tick(10);
    joystk2 = 16'h0010;
    self_test = 1'b1;
    ps2_ev(1'b1, 1'b0, 8'h2D);
    RESET = 1'b1; tick();
    RESET = 1'b0; tick(5);
    joystk2 = 16'h0000; self_test = 1'b0; tick(3);

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), codes[$urandom_range(0, 16)]};
      end
      if ($urandom_range(0, 5) == 0) joystk1 = 16'($urandom());
      if ($urandom_range(0, 5) == 0) joystk2 = 16'($urandom());
      if ($urandom_range(0, 15) == 0) self_test = ~self_test;
      RESET = ($urandom_range(0, 499) == 0);
      tick();
    end
    RESET = 1'b0;
    tick(3);

    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
